// File: rtl/spi_slave_mode_if.sv
// Purpose: pin- and register-side signal bundle of the SPI slave.
// Latency: none (wires only).
// Backpressure: RX_VALID is held until RX_ACK; no other flow control.
//
// Port summary:
//   SCK/SSEL/MOSI    asynchronous SPI inputs from the host
//   MISO/MISO_OE     serial data out and its pad enable
//   TX_DATA          frame to send, captured at frame start
//   RX_DATA/RX_VALID last received frame, held until RX_ACK
//   OVERRUN/ABORT    status: lost frame / early SSEL release
//   BUSY/BIT_CNT     frame in progress, bits sampled so far
interface spi_slave_mode_if #(
    parameter int LENGTH = 136
);
    logic              SCK;
    logic              SSEL;
    logic              MOSI;
    logic [LENGTH-1:0] TX_DATA;
    logic              RX_ACK;
    logic              MISO;
    logic              MISO_OE;
    logic [LENGTH-1:0] RX_DATA;
    logic              RX_VALID;
    logic              OVERRUN;
    logic              ABORT;
    logic              BUSY;
    logic [8:0]        BIT_CNT;

    // The SPI slave itself.
    modport slave (
        input  SCK, SSEL, MOSI, TX_DATA, RX_ACK,
        output MISO, MISO_OE, RX_DATA, RX_VALID, OVERRUN, ABORT, BUSY, BIT_CNT
    );

    // The pins' driver plus the register-bank consumer.
    modport master (
        output SCK, SSEL, MOSI, TX_DATA, RX_ACK,
        input  MISO, MISO_OE, RX_DATA, RX_VALID, OVERRUN, ABORT, BUSY, BIT_CNT
    );
endinterface

// File: rtl/spi_slave_mode.sv
// Purpose: oversampled SPI slave, all CPOL/CPHA modes, selectable bit order and frame length.
// Latency: RX_VALID rises SYNC_STAGES+1 CLK after the final sample edge at the pin.
// Backpressure: RX_VALID held until RX_ACK; a frame completing while still valid sets OVERRUN.
//
// Ports: CLK, RESET (synchronous, active-high) plain; everything else through
// spi_slave_mode_if.slave (SCK/SSEL/MOSI in, MISO/MISO_OE out, TX_DATA in,
// RX_DATA/RX_VALID/RX_ACK handshake, OVERRUN, ABORT, BUSY, BIT_CNT).
module spi_slave_mode #(
    parameter int LENGTH      = 136,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    spi_slave_mode_if.slave  bus
);

    localparam logic [8:0] LAST_BIT = 9'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // SCK carries one extra stage so the edge detector compares two
    // fully synchronised samples.
    logic [SYNC_STAGES:0]   sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] ssel_sync_q, ssel_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    // Fills with ones after reset; the SSEL chain holds real pin samples
    // only once it is full, so ARMED cannot be set by the reset value.
    logic [SYNC_STAGES-1:0] prime_q,     prime_d;

    logic              armed_q,    armed_d;
    logic [LENGTH-1:0] tx_sr_q,    tx_sr_d;
    logic [LENGTH-1:0] rx_sr_q,    rx_sr_d;
    logic [8:0]        bit_cnt_q,  bit_cnt_d;
    logic              miso_q,     miso_d;
    logic              miso_oe_q,  miso_oe_d;
    logic [LENGTH-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q,  overrun_d;
    logic              abort_q,    abort_d;

    logic              sck_new, sck_old;
    logic              ssel_s, mosi_s, primed;
    logic              lead_edge, trail_edge;
    logic              sample_edge, shift_edge;
    logic              frame_start, in_frame;
    logic [LENGTH-1:0] rx_next;

    // Bit-order helpers: the front bit is the next one to leave the tx shifter.
    function automatic logic tx_front(input logic [LENGTH-1:0] v);
        return LSB_FIRST ? v[0] : v[LENGTH-1];
    endfunction

    function automatic logic [LENGTH-1:0] tx_advance(input logic [LENGTH-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    // The first received bit ends up at the far end after LENGTH insertions.
    function automatic logic [LENGTH-1:0] rx_insert(input logic [LENGTH-1:0] v, input logic b);
        return LSB_FIRST ? {b, v[LENGTH-1:1]} : {v[LENGTH-2:0], b};
    endfunction

    assign sck_new = sck_sync_q[SYNC_STAGES-1];
    assign sck_old = sck_sync_q[SYNC_STAGES];
    assign ssel_s  = ssel_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign primed  = prime_q[SYNC_STAGES-1];

    assign lead_edge   = (sck_old == CPOL) && (sck_new != CPOL);
    assign trail_edge  = (sck_old != CPOL) && (sck_new == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign frame_start = (state_q == IDLE)  && !ssel_s && armed_q;
    // SSEL release outranks any SCK edge seen in the same cycle.
    assign in_frame    = (state_q == SHIFT) && !ssel_s;

    // State register and all other flops.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            sck_sync_q  <= {(SYNC_STAGES+1){CPOL}};
            ssel_sync_q <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            prime_q     <= '0;
            armed_q     <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            ssel_sync_q <= ssel_sync_d;
            mosi_sync_q <= mosi_sync_d;
            prime_q     <= prime_d;
            armed_q     <= armed_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            abort_q     <= abort_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = SHIFT;
            SHIFT: begin
                if (ssel_s)
                    state_d = IDLE;
                else if (sample_edge && (bit_cnt_q == LAST_BIT))
                    state_d = DONE;
            end
            DONE:    if (ssel_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-1:0], bus.SCK};
        ssel_sync_d = {ssel_sync_q[SYNC_STAGES-2:0], bus.SSEL};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
        prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};

        armed_d    = armed_q | (primed & ssel_s);
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        rx_next    = rx_insert(rx_sr_q, mosi_s);

        // Consumer ack; a completion below in the same cycle overrides it.
        if (bus.RX_ACK && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        if (frame_start) begin
            tx_sr_d   = bus.TX_DATA;
            rx_sr_d   = '0;
            bit_cnt_d = '0;
            // CPHA=0 has no leading shift edge before the first sample,
            // so the first bit must be on the pin at frame start.
            if (!CPHA) begin
                miso_d  = tx_front(bus.TX_DATA);
                tx_sr_d = tx_advance(bus.TX_DATA);
            end
        end

        if (in_frame && sample_edge) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + 9'd1;
            if (bit_cnt_q == LAST_BIT) begin
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !bus.RX_ACK)
                    overrun_d = 1'b1;
            end
        end

        // Edges are exclusive; the trailing edge after the last CPHA=0
        // sample arrives in DONE and so never advances MISO.
        if (in_frame && shift_edge) begin
            miso_d  = tx_front(tx_sr_q);
            tx_sr_d = tx_advance(tx_sr_q);
        end

        miso_oe_d = (state_d != IDLE);
        abort_d   = (state_q == SHIFT) && ssel_s;
    end

    // Output logic.
    always_comb begin
        bus.MISO     = miso_q;
        bus.MISO_OE  = miso_oe_q;
        bus.RX_DATA  = rx_data_q;
        bus.RX_VALID = rx_valid_q;
        bus.OVERRUN  = overrun_q;
        bus.ABORT    = abort_q;
        bus.BUSY     = (state_q != IDLE);
        bus.BIT_CNT  = bit_cnt_q;
    end

endmodule

// File: tb/tb_spi_slave_mode.sv
// Purpose: directed bench for spi_slave_mode: mode 0, mode 3 and LSB-first
// instances share SSEL/MOSI/RESET/RX_ACK and see equivalent SCK waveforms.
// Latency/backpressure: checked per scenario against hand-computed values.
module tb_spi_slave_mode;

    localparam int H = 8;  // CLK periods per SCK half-phase

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ssel, mosi, sck0, sck3, rx_ack;
    logic [7:0] tx, tx_lsb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] miso0_seen, miso3_seen, misol_seen;
    logic       rv_at2, rv_at3;
    logic       miso3_pre_edge, oe3_pre_edge, miso3_before;

    always #5 CLK = ~CLK;

    spi_slave_mode_if #(.LENGTH(8)) if0 ();
    spi_slave_mode_if #(.LENGTH(8)) if3 ();
    spi_slave_mode_if #(.LENGTH(8)) ifl ();

    assign if0.SCK = sck0;  assign if0.SSEL = ssel; assign if0.MOSI = mosi;
    assign if0.TX_DATA = tx;     assign if0.RX_ACK = rx_ack;
    assign if3.SCK = sck3;  assign if3.SSEL = ssel; assign if3.MOSI = mosi;
    assign if3.TX_DATA = tx;     assign if3.RX_ACK = rx_ack;
    assign ifl.SCK = sck0;  assign ifl.SSEL = ssel; assign ifl.MOSI = mosi;
    assign ifl.TX_DATA = tx_lsb; assign ifl.RX_ACK = rx_ack;

    spi_slave_mode #(.LENGTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0), .SYNC_STAGES(2))
        dut0 (.CLK(CLK), .RESET(RESET), .bus(if0));
    spi_slave_mode #(.LENGTH(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0), .SYNC_STAGES(2))
        dut3 (.CLK(CLK), .RESET(RESET), .bus(if3));
    spi_slave_mode #(.LENGTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1), .SYNC_STAGES(2))
        dutl (.CLK(CLK), .RESET(RESET), .bus(ifl));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Host-side master: SSEL low, then nbits of data MSB first. Mode 0 SCK
    // idles low; the mode 3 SCK idles high and falls just before each bit.
    // MISO is recorded at the end of each low phase, just before sampling.
    task automatic spi_bits(input logic [7:0] data, input int nbits);
        ssel = 1'b0;
        clks(H);
        miso3_pre_edge = if3.MISO;
        oe3_pre_edge   = if3.MISO_OE;
        for (int i = 0; i < nbits; i++) begin
            sck0 = 1'b0; sck3 = 1'b0; mosi = data[7-i];
            clks(H);
            miso0_seen[7-i] = if0.MISO;
            miso3_seen[7-i] = if3.MISO;
            misol_seen[7-i] = ifl.MISO;
            sck0 = 1'b1; sck3 = 1'b1;
            if (i == nbits - 1) begin
                clks(2); rv_at2 = if0.RX_VALID;
                clks(1); rv_at3 = if0.RX_VALID;
                clks(H - 3);
            end else begin
                clks(H);
            end
        end
        sck0 = 1'b0;
        clks(H);
    endtask

    task automatic spi_release();
        ssel = 1'b1;
        clks(H);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        clks(1);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; ssel = 1'b1; mosi = 1'b0; sck0 = 1'b0; sck3 = 1'b1;
        rx_ack = 1'b0; tx = 8'h00; tx_lsb = 8'h00;
        clks(4);
        RESET = 1'b0;
        clks(H);
        n_checks++; if (if0.MISO !== 1'b0)     begin n_fail++; $display("FAIL reset_miso: got %b want 0", if0.MISO); end
        n_checks++; if (if0.MISO_OE !== 1'b0)  begin n_fail++; $display("FAIL reset_miso_oe: got %b want 0", if0.MISO_OE); end
        n_checks++; if (if0.RX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", if0.RX_DATA); end
        n_checks++; if (if0.RX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", if0.RX_VALID); end
        n_checks++; if (if0.OVERRUN !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun: got %b want 0", if0.OVERRUN); end
        n_checks++; if (if0.ABORT !== 1'b0)    begin n_fail++; $display("FAIL reset_abort: got %b want 0", if0.ABORT); end
        n_checks++; if (if0.BUSY !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", if0.BUSY); end
        n_checks++; if (if0.BIT_CNT !== 9'd0)  begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", if0.BIT_CNT); end
    endtask

    task automatic test_mode0_mode3();
        tx = 8'hA5;
        miso3_before = if3.MISO;
        spi_bits(8'h3C, 8);
        n_checks++; if (miso0_seen !== 8'hA5)  begin n_fail++; $display("FAIL mode0_miso_seq: got %h want a5", miso0_seen); end
        n_checks++; if (rv_at2 !== 1'b0)       begin n_fail++; $display("FAIL mode0_valid_early: got %b want 0", rv_at2); end
        n_checks++; if (rv_at3 !== 1'b1)       begin n_fail++; $display("FAIL mode0_valid_latency: got %b want 1", rv_at3); end
        n_checks++; if (if0.RX_DATA !== 8'h3C) begin n_fail++; $display("FAIL mode0_rx_data: got %h want 3c", if0.RX_DATA); end
        n_checks++; if (if0.BIT_CNT !== 9'd8)  begin n_fail++; $display("FAIL mode0_bit_cnt: got %0d want 8", if0.BIT_CNT); end
        n_checks++; if (if0.MISO !== 1'b1)     begin n_fail++; $display("FAIL mode0_miso_hold: got %b want 1", if0.MISO); end
        n_checks++; if (if0.OVERRUN !== 1'b0)  begin n_fail++; $display("FAIL mode0_overrun: got %b want 0", if0.OVERRUN); end
        n_checks++; if (miso3_seen !== 8'hA5)  begin n_fail++; $display("FAIL mode3_miso_seq: got %h want a5", miso3_seen); end
        n_checks++; if (oe3_pre_edge !== 1'b1) begin n_fail++; $display("FAIL mode3_oe_pre: got %b want 1", oe3_pre_edge); end
        n_checks++; if (miso3_pre_edge !== miso3_before) begin n_fail++; $display("FAIL mode3_no_early_miso: got %b want %b", miso3_pre_edge, miso3_before); end
        n_checks++; if (if3.RX_DATA !== 8'h3C) begin n_fail++; $display("FAIL mode3_rx_data: got %h want 3c", if3.RX_DATA); end
        n_checks++; if (if3.RX_VALID !== 1'b1) begin n_fail++; $display("FAIL mode3_rx_valid: got %b want 1", if3.RX_VALID); end
        spi_release();
        n_checks++; if (if0.MISO_OE !== 1'b0)  begin n_fail++; $display("FAIL mode0_oe_idle: got %b want 0", if0.MISO_OE); end
        ack();
        n_checks++; if (if0.RX_VALID !== 1'b0) begin n_fail++; $display("FAIL mode0_ack: got %b want 0", if0.RX_VALID); end
    endtask

    task automatic test_lsb_first();
        tx = 8'h00; tx_lsb = 8'h01;
        spi_bits(8'h80, 8);
        spi_release();
        n_checks++; if (misol_seen[7] !== 1'b1) begin n_fail++; $display("FAIL lsb_first_miso_bit: got %b want 1", misol_seen[7]); end
        n_checks++; if (misol_seen !== 8'h80)   begin n_fail++; $display("FAIL lsb_miso_seq: got %h want 80", misol_seen); end
        n_checks++; if (ifl.RX_DATA !== 8'h01)  begin n_fail++; $display("FAIL lsb_rx_data: got %h want 01", ifl.RX_DATA); end
        n_checks++; if (if0.RX_DATA !== 8'h80)  begin n_fail++; $display("FAIL msb_rx_data: got %h want 80", if0.RX_DATA); end
        ack();
    endtask

    task automatic test_abort();
        spi_bits(8'hFF, 5);
        n_checks++; if (if0.BIT_CNT !== 9'd5) begin n_fail++; $display("FAIL abort_bit_cnt: got %0d want 5", if0.BIT_CNT); end
        ssel = 1'b1;
        clks(2);
        n_checks++; if (if0.BUSY !== 1'b1)  begin n_fail++; $display("FAIL abort_busy_early: got %b want 1", if0.BUSY); end
        n_checks++; if (if0.ABORT !== 1'b0) begin n_fail++; $display("FAIL abort_early: got %b want 0", if0.ABORT); end
        clks(1);
        n_checks++; if (if0.BUSY !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got %b want 0", if0.BUSY); end
        n_checks++; if (if0.ABORT !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b want 1", if0.ABORT); end
        clks(1);
        n_checks++; if (if0.ABORT !== 1'b0)    begin n_fail++; $display("FAIL abort_width: got %b want 0", if0.ABORT); end
        n_checks++; if (if0.RX_VALID !== 1'b0) begin n_fail++; $display("FAIL abort_rx_valid: got %b want 0", if0.RX_VALID); end
        n_checks++; if (if0.RX_DATA !== 8'h80) begin n_fail++; $display("FAIL abort_rx_data: got %h want 80", if0.RX_DATA); end
        clks(H);
    endtask

    task automatic test_back_to_back_overrun();
        tx = 8'h0F;
        spi_bits(8'h11, 8);
        spi_release();
        n_checks++; if (if0.RX_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", if0.RX_VALID); end
        n_checks++; if (if0.OVERRUN !== 1'b0)  begin n_fail++; $display("FAIL b2b_first_overrun: got %b want 0", if0.OVERRUN); end
        spi_bits(8'h22, 8);
        spi_release();
        n_checks++; if (if0.RX_DATA !== 8'h22) begin n_fail++; $display("FAIL b2b_rx_data: got %h want 22", if0.RX_DATA); end
        n_checks++; if (if0.OVERRUN !== 1'b1)  begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", if0.OVERRUN); end
        ack();
        n_checks++; if (if0.RX_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_valid: got %b want 0", if0.RX_VALID); end
        n_checks++; if (if0.OVERRUN !== 1'b0)  begin n_fail++; $display("FAIL b2b_ack_overrun: got %b want 0", if0.OVERRUN); end
    endtask

    task automatic test_reset_midframe();
        spi_bits(8'hFF, 4);
        RESET = 1'b1;
        clks(2);
        RESET = 1'b0;
        spi_bits(8'hF0, 4);
        n_checks++; if (if0.BUSY !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", if0.BUSY); end
        spi_release();
        n_checks++; if (if0.RX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rx_valid: got %b want 0", if0.RX_VALID); end
        n_checks++; if (if0.RX_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rx_data: got %h want 00", if0.RX_DATA); end
        tx = 8'hC3;
        spi_bits(8'h5A, 8);
        spi_release();
        n_checks++; if (miso0_seen !== 8'hC3)  begin n_fail++; $display("FAIL rst_new_miso_seq: got %h want c3", miso0_seen); end
        n_checks++; if (if0.RX_DATA !== 8'h5A) begin n_fail++; $display("FAIL rst_new_rx_data: got %h want 5a", if0.RX_DATA); end
        n_checks++; if (if0.RX_VALID !== 1'b1) begin n_fail++; $display("FAIL rst_new_rx_valid: got %b want 1", if0.RX_VALID); end
        n_checks++; if (if0.BIT_CNT !== 9'd8)  begin n_fail++; $display("FAIL rst_new_bit_cnt: got %0d want 8", if0.BIT_CNT); end
    endtask

    initial begin
        test_reset();
        test_mode0_mode3();
        test_lsb_first();
        test_abort();
        test_back_to_back_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
